// File: rtl/random_range_gen.sv
// Pseudorandom number source returning values uniformly drawn from 0..max_number
// over a req/valid handshake, backed by a wrap counter or a seedable Galois LFSR.
module random_range_gen #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     LFSR_TAPS = 8'hB8,
  parameter logic [WIDTH-1:0]     SEED      = 8'h01,
  parameter int unsigned          MAX_TRIES = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             mode,
  input  logic [WIDTH-1:0] max_number,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] num_out,
  output logic             fallback
);

  localparam int unsigned      TRY_W   = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

  typedef enum logic {IDLE, SAMPLE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_counter;
  logic [WIDTH-1:0] r_max_q;
  logic             r_mode_q;
  logic [TRY_W-1:0] r_tries;
  logic             r_ready;
  logic             r_valid;
  logic             r_fallback;
  logic [WIDTH-1:0] r_num;

  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_cand;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_max_nxt;
  logic             w_mode_nxt;
  logic [TRY_W-1:0] w_tries_nxt;
  logic             w_valid_nxt;
  logic             w_fallback_nxt;
  logic [WIDTH-1:0] w_num_nxt;

  // Random sources run every cycle regardless of the handshake; load beats step
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_lfsr    <= SEED_NZ;
      r_counter <= '0;
    end else begin
      if (seed_load)
        r_lfsr <= (seed == '0) ? WIDTH'(1) : seed;
      else
        r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
      r_counter <= (r_counter >= max_number) ? '0 : r_counter + WIDTH'(1);
    end
  end

  // Smear the latched bound rightwards to get the covering 2^k-1 mask
  always_comb begin
    w_mask = r_max_q;
    for (int i = 1; i < int'(WIDTH); i++)
      w_mask = w_mask | (w_mask >> i);
  end

  assign w_cand   = r_mode_q ? (r_lfsr & w_mask) : r_counter;
  assign w_accept = (w_cand <= r_max_q);
  assign w_last   = (r_tries == TRY_W'(MAX_TRIES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req) w_state_nxt = SAMPLE;
      SAMPLE:  if (w_accept || w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_max_nxt      = r_max_q;
    w_mode_nxt     = r_mode_q;
    w_tries_nxt    = r_tries;
    w_valid_nxt    = 1'b0;
    w_fallback_nxt = r_fallback;
    w_num_nxt      = r_num;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_max_nxt   = max_number;
          w_mode_nxt  = mode;
          w_tries_nxt = '0;
        end
      end
      SAMPLE: begin
        if (w_accept) begin
          w_num_nxt      = w_cand;
          w_fallback_nxt = 1'b0;
          w_valid_nxt    = 1'b1;
        end else if (w_last) begin
          // Halving the masked draw always lands inside 0..max_q
          w_num_nxt      = (w_cand & w_mask) >> 1;
          w_fallback_nxt = 1'b1;
          w_valid_nxt    = 1'b1;
        end else begin
          w_tries_nxt = r_tries + TRY_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_max_q    <= '0;
      r_mode_q   <= 1'b0;
      r_tries    <= '0;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
      r_fallback <= 1'b0;
      r_num      <= '0;
    end else begin
      r_max_q    <= w_max_nxt;
      r_mode_q   <= w_mode_nxt;
      r_tries    <= w_tries_nxt;
      r_ready    <= (w_state_nxt == IDLE);
      r_valid    <= w_valid_nxt;
      r_fallback <= w_fallback_nxt;
      r_num      <= w_num_nxt;
    end
  end

  assign ready    = r_ready;
  assign valid    = r_valid;
  assign num_out  = r_num;
  assign fallback = r_fallback;

endmodule

// File: tb/tb_random_range_gen.sv
// Directed bench for random_range_gen: default instance plus a MAX_TRIES=1 instance
// sharing the same stimulus to exercise the fallback path.
module tb_random_range_gen;

  logic       clock = 1'b0;
  logic       resetn;
  logic       mode;
  logic [7:0] max_number;
  logic       seed_load;
  logic [7:0] seed;
  logic       req;

  logic       ready0, valid0, fallback0;
  logic [7:0] num0;
  logic       ready1, valid1, fallback1;
  logic [7:0] num1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  random_range_gen dut (
    .clock(clock), .resetn(resetn), .mode(mode), .max_number(max_number),
    .seed_load(seed_load), .seed(seed), .req(req),
    .ready(ready0), .valid(valid0), .num_out(num0), .fallback(fallback0)
  );

  random_range_gen #(.MAX_TRIES(1)) dut1 (
    .clock(clock), .resetn(resetn), .mode(mode), .max_number(max_number),
    .seed_load(seed_load), .seed(seed), .req(req),
    .ready(ready1), .valid(valid1), .num_out(num1), .fallback(fallback1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One request on the default instance; leaves the bench in the valid cycle
  task automatic get_num(output logic [7:0] n, output logic fb, output int lat);
    chk("ready_before_req", 32'(ready0), 32'd1);
    req = 1'b1;
    tick();
    req = 1'b0;
    lat = 0;
    while (!valid0 && lat < 40) begin
      tick();
      lat++;
    end
    chk("valid_seen", 32'(valid0), 32'd1);
    chk("ready_with_valid", 32'(ready0), 32'd1);
    n  = num0;
    fb = fallback0;
  endtask

  logic [7:0] n;
  logic       fb;
  int         lat;
  int         cnt;

  initial begin
    resetn = 1'b0; mode = 1'b0; max_number = 8'd0;
    seed_load = 1'b0; seed = 8'd0; req = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(ready0), 32'd1);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_num", 32'(num0), 32'd0);
    chk("rst_fallback", 32'(fallback0), 32'd0);
    chk("rst_lfsr", 32'(dut.r_lfsr), 32'h01);
    resetn = 1'b1;
    tick();

    // Seeded LFSR sequence: 01 -> B8 -> 5C -> 2E -> 17 -> B3
    mode = 1'b1; max_number = 8'hFF;
    seed = 8'h01; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    get_num(n, fb, lat);
    chk("seq0_num", 32'(n), 32'hB8);
    chk("seq0_fb", 32'(fb), 32'd0);
    chk("seq0_lat", 32'(lat), 32'd1);
    get_num(n, fb, lat);
    chk("seq1_num", 32'(n), 32'h2E);
    chk("seq1_lat", 32'(lat), 32'd1);
    get_num(n, fb, lat);
    chk("seq2_num", 32'(n), 32'hB3);
    chk("seq2_fb", 32'(fb), 32'd0);
    tick();
    chk("valid_one_cycle", 32'(valid0), 32'd0);

    // Fallback on the MAX_TRIES=1 instance; default instance redraws instead
    max_number = 8'h20; seed = 8'h01; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    chk("fb_valid", 32'(valid1), 32'd1);
    chk("fb_num", 32'(num1), 32'h1C);
    chk("fb_flag", 32'(fallback1), 32'd1);
    chk("redraw_busy", 32'(ready0), 32'd0);
    tick();
    chk("redraw_valid", 32'(valid0), 32'd1);
    chk("redraw_num", 32'(num0), 32'h1C);
    chk("redraw_fb", 32'(fallback0), 32'd0);
    repeat (3) tick();

    // Counter mode, back-to-back requests
    mode = 1'b0; max_number = 8'd5;
    for (int i = 0; i < 30; i++) begin
      get_num(n, fb, lat);
      chk("cnt_range", 32'(n <= 8'd5), 32'd1);
      chk("cnt_fb", 32'(fb), 32'd0);
      chk("cnt_lat", 32'(lat), 32'd1);
    end
    tick();

    // Degenerate range in both modes
    max_number = 8'd0;
    for (int m = 0; m < 2; m++) begin
      mode = 1'(m);
      for (int i = 0; i < 10; i++) begin
        get_num(n, fb, lat);
        chk("zero_range_num", 32'(n), 32'd0);
        chk("zero_range_fb", 32'(fb), 32'd0);
      end
      tick();
    end

    // Zero seed is replaced by 1 and the LFSR never hits 0
    seed = 8'h00; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("zero_seed_lfsr", 32'(dut.r_lfsr), 32'h01);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (dut.r_lfsr == 8'h00) cnt++;
    end
    chk("lfsr_never_zero", 32'(cnt), 32'd0);

    // Reset during SAMPLE aborts the request
    mode = 1'b1; max_number = 8'h20;
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("in_sample", 32'(ready0), 32'd0);
    resetn = 1'b0;
    #1;
    chk("abort_valid", 32'(valid0), 32'd0);
    chk("abort_ready", 32'(ready0), 32'd1);
    chk("abort_num", 32'(num0), 32'd0);
    tick();
    resetn = 1'b1;

    // No request, no result
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (valid0) cnt++;
    end
    chk("idle_no_valid", 32'(cnt), 32'd0);
    chk("idle_ready", 32'(ready0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/random_range_gen.md
Name: random_range_gen

Overview:
- Parametrised pseudorandom number source for game logic, e.g. food placement.
- On each request it returns one number uniformly drawn from 0..max_number inclusive, using request/valid handshakes.
- The random source is either a free-running wrap counter (mode 0) or a seedable Galois LFSR (mode 1).
- Out-of-range LFSR draws are rejected and redrawn, with a bounded retry count and a guaranteed in-range fallback.

Parameters:
- WIDTH, 8: width of max_number, seed, num_out, LFSR and counter.
- LFSR_TAPS, 8'hB8: Galois feedback mask, XORed in when the shifted-out bit is 1.
- SEED, 8'h01: LFSR reset value; a value of 0 is replaced by 1.
- MAX_TRIES, 16: maximum draws per request before fallback; must be 1 or more.

Ports:
- clock, in, 1: single clock, rising edge.
- resetn, in, 1: asynchronous active-low reset.
- mode, in, 1: source select, 0 = wrap counter, 1 = LFSR; sampled at request acceptance.
- max_number, in, WIDTH: inclusive upper bound; sampled at request acceptance.
- seed_load, in, 1: load seed into the LFSR this cycle.
- seed, in, WIDTH: LFSR seed value.
- req, in, 1: request a number.
- ready, out, 1: block can accept req; high exactly in IDLE.
- valid, out, 1: one-cycle pulse; num_out is new this cycle.
- num_out, out, WIDTH: result; held until the next valid.
- fallback, out, 1: qualifies valid; 1 = retry limit hit, fallback value used.

Behaviour:
- Reset (asynchronous, resetn=0):
  - lfsr = SEED, or 1 if SEED is 0; counter = 0; state = IDLE.
  - num_out = 0, valid = 0, fallback = 0, tries = 0, ready = 1.
- LFSR, every cycle, independent of state:
  - If seed_load=1: lfsr <= seed, or 1 if seed is 0. Load takes priority over stepping.
  - Else: lfsr <= (lfsr >> 1) XOR (lfsr[0] ? LFSR_TAPS : 0).
  - The all-zero state is unreachable.
- Counter, every cycle: counter <= (counter >= max_number) ? 0 : counter + 1. Comparison uses the live max_number.
- mask is derived from max_q: the smallest 2^k-1 with 2^k-1 >= max_q. max_q = 0 gives mask = 0.
- State machine:
  - IDLE: ready = 1. On req=1, latch max_q <= max_number and mode_q <= mode, clear tries, go to SAMPLE.
  - SAMPLE: ready = 0. Candidate cand = mode_q ? (lfsr & mask) : counter.
    - If cand <= max_q: num_out <= cand, fallback <= 0, valid <= 1, go to IDLE.
    - Else if tries == MAX_TRIES-1: num_out <= (cand & mask) >> 1, which is always <= max_q; fallback <= 1, valid <= 1, go to IDLE.
    - Else: tries <= tries + 1, stay in SAMPLE. The LFSR/counter has advanced, so the next draw is new.
- Latency:
  - req accepted at edge N gives valid at cycle N+2 when the first draw is accepted.
  - Worst case is N+1+MAX_TRIES.
- valid is high for exactly one cycle, coinciding with ready = 1.
- A req held high in that cycle is accepted, so back-to-back requests yield one result every 2 cycles minimum.
- Changes to max_number or mode during SAMPLE do not affect the request in flight.
- Mode 0 normally accepts on the first draw. It rejects only if max_q < counter, and the counter then wraps to 0 within one cycle.
- seed_load during SAMPLE is legal; the next draw uses the loaded value.
- Reset mid-SAMPLE aborts the request: no valid, state IDLE.
- The tries counter width is clog2(MAX_TRIES) bits, minimum 1.

Test Plan:
- Seeded LFSR sequence:
  - Stimulus: mode=1, max_number=8'hFF, seed=8'h01, seed_load high for one cycle at edge T, req high at edge T+1.
  - Required: valid at T+3 with num_out=8'hB8, fallback=0.
  - Continued back-to-back requests return 8'h2E, then 8'hB3 (LFSR sequence 01, B8, 5C, 2E, 17, B3).
- Counter mode:
  - Stimulus: mode=0, max_number=5, 30 back-to-back requests.
  - Required: every num_out in 0..5, fallback=0, exactly one valid per accepted req, each 2 cycles after acceptance.
- Fallback:
  - Stimulus: MAX_TRIES=1, mode=1, max_number=8'h20, seed 8'h01 loaded at T, req at T+1.
  - Required: draw 8'hB8 & 8'h3F = 8'h38 > 8'h20 is rejected, so valid at T+3 with num_out=8'h1C, fallback=1.
- Degenerate range:
  - Stimulus: max_number=0 in both modes, 10 requests each.
  - Required: num_out=0, fallback=0 every time.
- Zero seed:
  - Stimulus: seed_load with seed=0.
  - Required: lfsr=8'h01 the next cycle, and the LFSR never reaches 0 over 300 cycles.
- Reset and request handling:
  - Assert resetn=0 during SAMPLE: no valid, ready=1, num_out=0.
  - Hold req low after reset: no valid ever appears.
